// File: rtl/aludec_mdu.sv
// ---------------------------------------------------------------------------
// aludec_mdu
//
// ALU control decoder plus an iterative multiply/divide unit with HI/LO
// registers. Plain ALU ops decode combinationally with zero latency.
// mult/multu/div/divu run one bit per cycle on operand magnitudes, and the
// result signs are fixed when the operation finishes.
//
// Optional build macro: ALUDEC_MD_EARLY_EXIT_EN
//   When defined, a multiply finishes on the first edge at which the
//   remaining multiplier bits are all zero. Results are the same either way.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   valid        instruction in decode/execute is real (not a bubble)
//   funct        instruction funct field
//   aluop        00 add, 01 sub, 10 use funct, 11 slt
//   srca, srcb   operands (dividend/multiplicand, divisor/multiplier)
//   alucontrol   ALU operation select
//   illegal      unrecognised funct when aluop=10 and valid=1
//   stall        hold the pipeline this cycle
//   md_busy      multiply/divide in progress
//   md_done      one-cycle pulse after HI/LO are updated by mult/div
//   hi, lo       HI/LO registers
//
// State table:
//   state  | meaning
//   S_IDLE | no mult/div in flight; mthi/mtlo may write; a new op may start
//   S_RUN  | mult/div iterating; finishes on the last bit or on divide by zero
// ---------------------------------------------------------------------------
module aludec_mdu #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [5:0]        funct,
    input  logic [1:0]        aluop,
    input  logic [WIDTH-1:0]  srca,
    input  logic [WIDTH-1:0]  srcb,
    output logic [CTRL_W-1:0] alucontrol,
    output logic              illegal,
    output logic              stall,
    output logic              md_busy,
    output logic              md_done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int                 CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    logic [3:0] alu_code;

    always_comb begin
        alu_code = ALU_AND;
        illegal  = 1'b0;
        case (aluop)
            2'b00: alu_code = ALU_ADD;
            2'b01: alu_code = ALU_SUB;
            2'b11: alu_code = ALU_SLT;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alu_code = ALU_ADD;
                    6'b100010, 6'b100011: alu_code = ALU_SUB;
                    6'b100100:            alu_code = ALU_AND;
                    6'b100101:            alu_code = ALU_OR;
                    6'b100110:            alu_code = ALU_XOR;
                    6'b100111:            alu_code = ALU_NOR;
                    6'b101010:            alu_code = ALU_SLT;
                    6'b101011:            alu_code = ALU_SLTU;
                    6'b000000:            alu_code = ALU_SLL;
                    6'b000010:            alu_code = ALU_SRL;
                    6'b000011:            alu_code = ALU_SRA;
                    6'b010000, 6'b010001, 6'b010010, 6'b010011,
                    6'b011000, 6'b011001, 6'b011010, 6'b011011:
                                          alu_code = ALU_ADD;
                    default: begin
                        alu_code = ALU_AND;
                        illegal  = valid;
                    end
                endcase
            end
        endcase
    end

    assign alucontrol = CTRL_W'(alu_code);

    // ------------------------------------------------------------------
    // MD control
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_div_q, op_div_d;
    logic                dz_q, dz_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    // acc: multiply accumulator, or {remainder, quotient} for divide.
    // mcand: shifted multiplicand, or divisor in the low half for divide.
    // mplier: remaining multiplier bits, or raw dividend for divide by zero.
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [2*WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic                md_done_q, md_done_d;

    logic r_type, is_md_op, is_hilo_acc, md_start, mthi_wr, mtlo_wr;

    assign md_busy     = (state_q == S_RUN);
    assign r_type      = valid & (aluop == 2'b10);
    assign is_md_op    = (funct[5:2] == 4'b0110);
    assign is_hilo_acc = (funct[5:2] == 4'b0100);
    assign stall       = r_type & md_busy & (is_md_op | is_hilo_acc);
    assign md_start    = r_type & is_md_op & ~md_busy;
    assign mthi_wr     = r_type & (funct == 6'b010001) & ~md_busy;
    assign mtlo_wr     = r_type & (funct == 6'b010011) & ~md_busy;

    // Signed variants (mult, div) have funct[0] clear.
    logic             signed_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign signed_op = ~funct[0];
    assign a_neg     = signed_op & srca[WIDTH-1];
    assign b_neg     = signed_op & srcb[WIDTH-1];
    assign mag_a     = a_neg ? (~srca + ONE_W) : srca;
    assign mag_b     = b_neg ? (~srcb + ONE_W) : srcb;

    // One iteration of each algorithm.
    logic [2*WIDTH-1:0] mul_acc_step, mul_mcand_step, mul_prod;
    logic [WIDTH-1:0]   mul_mplier_step;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   div_rem_step, div_quo_step, div_rem_fix, div_quo_fix;
    logic               last_iter, mul_fin;

    assign mul_acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_mcand_step  = {mcand_q[2*WIDTH-2:0], 1'b0};
    assign mul_mplier_step = {1'b0, mplier_q[WIDTH-1:1]};
    assign mul_prod        = neg_res_q ? (~mul_acc_step + ONE_2W) : mul_acc_step;

    // Restoring divide: a borrow in bit WIDTH means the trial subtract failed.
    assign div_shift    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff     = div_shift - {1'b0, mcand_q[WIDTH-1:0]};
    assign div_rem_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_quo_step = {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
    assign div_quo_fix  = neg_res_q ? (~div_quo_step + ONE_W) : div_quo_step;
    assign div_rem_fix  = neg_rem_q ? (~div_rem_step + ONE_W) : div_rem_step;

    assign last_iter = (cnt_q == CNT_LAST);

`ifdef ALUDEC_MD_EARLY_EXIT_EN
    // Multiplicand is shifted into place every step, so the accumulator
    // already holds the final product once no multiplier bits remain.
    assign mul_fin = last_iter | (mul_mplier_step == '0);
`else
    assign mul_fin = last_iter;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        dz_d      = dz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        md_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mthi_wr) hi_d = srca;
                if (mtlo_wr) lo_d = srca;
                if (md_start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    op_div_d  = funct[1];
                    dz_d      = funct[1] & (srcb == '0);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (funct[1]) begin
                        acc_d    = {{WIDTH{1'b0}}, mag_a};
                        mcand_d  = {{WIDTH{1'b0}}, mag_b};
                        mplier_d = srca;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, mag_a};
                        mplier_d = mag_b;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_div_q) begin
                    acc_d = {div_rem_step, div_quo_step};
                    if (dz_q || last_iter) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        md_done_d = 1'b1;
                        hi_d      = dz_q ? mplier_q : div_rem_fix;
                        lo_d      = dz_q ? '1 : div_quo_fix;
                    end
                end else begin
                    acc_d    = mul_acc_step;
                    mcand_d  = mul_mcand_step;
                    mplier_d = mul_mplier_step;
                    if (mul_fin) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        md_done_d = 1'b1;
                        hi_d      = mul_prod[2*WIDTH-1:WIDTH];
                        lo_d      = mul_prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            dz_q      <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            dz_q      <= dz_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_done = md_done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_aludec_mdu.sv
// Bench for aludec_mdu at WIDTH=32: an arithmetic reference model checked
// every cycle, plus directed vectors with literal expected values.
module tb_aludec_mdu;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid   = 1'b0;
    logic [5:0]  funct   = 6'b0;
    logic [1:0]  aluop   = 2'b0;
    logic [31:0] srca    = 32'b0;
    logic [31:0] srcb    = 32'b0;
    logic [3:0]  alucontrol;
    logic        illegal, stall, md_busy, md_done;
    logic [31:0] hi, lo;

    aludec_mdu dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid      (valid),
        .funct      (funct),
        .aluop      (aluop),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .stall      (stall),
        .md_busy    (md_busy),
        .md_done    (md_done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

`ifdef ALUDEC_MD_EARLY_EXIT_EN
    localparam int LAT_B5 = 3;
    localparam int LAT_B4 = 3;
`else
    localparam int LAT_B5 = 32;
    localparam int LAT_B4 = 32;
`endif

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [4:0] exp_dec(input logic v, input logic [1:0] op, input logic [5:0] f);
        logic [3:0] c;
        logic       ill;
        c   = 4'b0000;
        ill = 1'b0;
        if (op == 2'b00)      c = 4'b0010;
        else if (op == 2'b01) c = 4'b0110;
        else if (op == 2'b11) c = 4'b0111;
        else begin
            case (f)
                6'b100000, 6'b100001: c = 4'b0010;
                6'b100010, 6'b100011: c = 4'b0110;
                6'b100100: c = 4'b0000;
                6'b100101: c = 4'b0001;
                6'b100110: c = 4'b0011;
                6'b100111: c = 4'b0100;
                6'b101010: c = 4'b0111;
                6'b101011: c = 4'b1000;
                6'b000000: c = 4'b0101;
                6'b000010: c = 4'b1001;
                6'b000011: c = 4'b1010;
                6'b010000, 6'b010001, 6'b010010, 6'b010011,
                6'b011000, 6'b011001, 6'b011010, 6'b011011: c = 4'b0010;
                default: ill = v;
            endcase
        end
        return {ill, c};
    endfunction

    function automatic bit stall_class(input logic [5:0] f);
        return f inside {6'b010000, 6'b010010, 6'b010001, 6'b010011,
                         6'b011000, 6'b011001, 6'b011010, 6'b011011};
    endfunction

    function automatic int mul_latency(input logic [31:0] b, input bit is_signed);
`ifdef ALUDEC_MD_EARLY_EXIT_EN
        logic [31:0] m;
        int lat;
        m   = (is_signed && b[31]) ? (32'd0 - b) : b;
        lat = 1;
        for (int i = 0; i < 32; i++) if (m[i]) lat = i + 1;
        return lat;
`else
        return 32 + 0 * int'(b[0] ^ is_signed);
`endif
    endfunction

    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_hi = 32'b0, m_lo = 32'b0, r_hi = 32'b0, r_lo = 32'b0;

    task automatic model_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, q, r;
        case (f)
            6'b011000: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r_hi = p[63:32]; r_lo = p[31:0];
                m_left = mul_latency(b, 1'b1);
            end
            6'b011001: begin
                p = {32'b0, a} * {32'b0, b};
                r_hi = p[63:32]; r_lo = p[31:0];
                m_left = mul_latency(b, 1'b0);
            end
            6'b011010: begin
                if (b == 32'b0) begin
                    r_lo = 32'hFFFF_FFFF; r_hi = a; m_left = 1;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    q  = sa / sb;
                    r  = sa % sb;
                    r_lo = q[31:0]; r_hi = r[31:0]; m_left = 32;
                end
            end
            default: begin
                if (b == 32'b0) begin
                    r_lo = 32'hFFFF_FFFF; r_hi = a; m_left = 1;
                end else begin
                    r_lo = a / b; r_hi = a % b; m_left = 32;
                end
            end
        endcase
        m_busy = 1'b1;
    endtask

    always @(posedge clk or negedge reset_n) begin
        bit nd;
        if (!reset_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_left = 0;
            m_hi = 32'b0;  m_lo = 32'b0;
        end else begin
            nd = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; nd = 1'b1;
                end
            end else if (valid && aluop == 2'b10) begin
                if (funct inside {6'b011000, 6'b011001, 6'b011010, 6'b011011})
                    model_start(funct, srca, srcb);
                else if (funct == 6'b010001) m_hi = srca;
                else if (funct == 6'b010011) m_lo = srca;
            end
            m_done = nd;
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (cmp_en) begin
            e = exp_dec(valid, aluop, funct);
            chk("m_alucontrol", 64'(alucontrol), 64'(e[3:0]));
            chk("m_illegal", 64'(illegal), 64'(e[4]));
            chk("m_stall", 64'(stall), 64'(valid && aluop == 2'b10 && m_busy && stall_class(funct)));
            chk("m_busy", 64'(md_busy), 64'(m_busy));
            chk("m_done", 64'(md_done), 64'(m_done));
            chk("m_hi", 64'(hi), 64'(m_hi));
            chk("m_lo", 64'(lo), 64'(m_lo));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        valid = 1'b1; aluop = 2'b10; funct = f; srca = a; srcb = b;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
            else if (md_busy) lat++;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat);
        int lat;
        issue(f, a, b);
        wait_done(name, lat);
        chk({name, "_lat"}, 64'(lat), 64'(elat));
        chk({name, "_hi"}, 64'(hi), 64'(eh));
        chk({name, "_lo"}, 64'(lo), 64'(el));
    endtask

    task automatic write_hilo(input logic [5:0] f, input logic [31:0] a);
        @(posedge clk); #1;
        valid = 1'b1; aluop = 2'b10; funct = f; srca = a;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    logic [1:0] d_op   [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11};
    logic [5:0] d_fn   [10] = '{6'b100111, 6'b000011, 6'b101011, 6'b111111, 6'b010000,
                                6'b000000, 6'b100010, 6'b000000, 6'b000000, 6'b000000};
    logic [3:0] d_code [10] = '{4'b0100, 4'b1010, 4'b1000, 4'b0000, 4'b0010,
                                4'b0101, 4'b0110, 4'b0010, 4'b0110, 4'b0111};
    logic       d_ill  [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_done", 64'(md_done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            valid = 1'b1; aluop = d_op[i]; funct = d_fn[i];
            @(negedge clk);
            chk("dec_code", 64'(alucontrol), 64'(d_code[i]));
            chk("dec_illegal", 64'(illegal), 64'(d_ill[i]));
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            valid = 1'b0; aluop = d_op[i]; funct = d_fn[i];
            @(negedge clk);
            chk("dec_bubble_code", 64'(alucontrol), 64'(d_code[i]));
            chk("dec_bubble_illegal", 64'(illegal), 64'd0);
        end
        @(posedge clk); #1;
        valid = 1'b0; aluop = 2'b00; funct = 6'b0;

        run_md("mult_neg3x5",  6'b011000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_B5);
        run_md("multu_neg3x5", 6'b011001, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, LAT_B5);
        run_md("divu_100_7",   6'b011011, 32'd100, 32'd7, 32'd2, 32'd14, 32);
        run_md("div_m7_2",     6'b011010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32);
        run_md("div_ovf",      6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32);
        run_md("div_by_zero",  6'b011010, 32'd1234, 32'd0, 32'd1234, 32'hFFFF_FFFF, 1);

        // mflo waiting on an in-flight multiply
        issue(6'b011001, 32'd1000, 32'd1000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        valid = 1'b1; aluop = 2'b10; funct = 6'b010010;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (md_done) begin
                seen = 1'b1;
                chk("mflo_stall_released", 64'(stall), 64'd0);
                chk("mflo_lo_new", 64'(lo), 64'h000F_4240);
            end else begin
                chk("mflo_stall_held", 64'(stall), 64'd1);
            end
        end
        chk("mflo_done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        valid = 1'b0;

        // mthi/mtlo when idle, then mthi blocked while busy
        write_hilo(6'b010001, 32'hCAFE_F00D);
        @(negedge clk);
        chk("mthi_idle", 64'(hi), 64'hCAFE_F00D);
        write_hilo(6'b010011, 32'h0BAD_BEEF);
        @(negedge clk);
        chk("mtlo_idle", 64'(lo), 64'h0BAD_BEEF);

        issue(6'b011001, 32'h0001_0000, 32'h0003_0000);
        valid = 1'b1; aluop = 2'b10; funct = 6'b010001; srca = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mthi_busy_stall", 64'(stall), 64'd1);
            chk("mthi_busy_hi", 64'(hi), 64'hCAFE_F00D);
        end
        @(posedge clk); #1;
        valid = 1'b0;
        wait_done("mthi_busy_mult", lat);
        chk("mthi_busy_mult_hi", 64'(hi), 64'h0000_0003);
        chk("mthi_busy_mult_lo", 64'(lo), 64'h0000_0000);

        // Asynchronous reset in the middle of a divide
        write_hilo(6'b010011, 32'h0000_5A5A);
        issue(6'b011011, 32'hFFFF_FFFF, 32'd3);
        repeat (9) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(md_busy), 64'd0);
        chk("midrst_done", 64'(md_done), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_md("mult_after_rst", 6'b011000, 32'd3, 32'd4, 32'd0, 32'd12, LAT_B4);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
